// File: rtl/trs_port_bridge_if.sv
// Bus-side and ESP-side signal bundle for trs_port_bridge.
// slave = the bridge itself; master = bus front-end plus ESP command engine.
interface trs_port_bridge_if;
  logic [7:0]  a_in;
  logic [7:0]  d_in;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic        m1_n;
  logic [7:0]  d_out;
  logic        d_oe;
  logic        wait_out;
  logic        evt_valid;
  logic [16:0] evt_data;
  logic        evt_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_data;

  // evt: an entry transfers on every clk_in edge where evt_valid & evt_ready;
  // evt_data is stable while evt_valid is high. rsp_valid is a one-cycle pulse.
  modport slave (
    input  a_in, d_in, iorq_n, rd_n, wr_n, m1_n, evt_ready, rsp_valid, rsp_data,
    output d_out, d_oe, wait_out, evt_valid, evt_data
  );

  modport master (
    output a_in, d_in, iorq_n, rd_n, wr_n, m1_n, evt_ready, rsp_valid, rsp_data,
    input  d_out, d_oe, wait_out, evt_valid, evt_data
  );
endinterface

// File: rtl/trs_port_bridge.sv
// Z80 I/O-port bridge: decodes IN/OUT to a port window, queues events for the ESP side.
// Optional IN timeout enabled by defining TRS_BRIDGE_TIMEOUT_EN.
module trs_port_bridge #(
  parameter logic [7:0] BASE_PORT    = 8'hE0,
  parameter int         NUM_PORTS    = 8,
  parameter int         FIFO_DEPTH   = 16,
  parameter int         WAIT_TIMEOUT = 4096
) (
  input  logic              clk_in,
  input  logic              reset_n,
  trs_port_bridge_if.slave  bus,
  output logic              timeout_flag,
  output logic [2:0]        state_dbg
);
  localparam int         AW        = $clog2(FIFO_DEPTH);
  localparam int         CW        = AW + 1;
  localparam logic [7:0] PORT_MASK = ~8'(NUM_PORTS - 1);

  if (((BASE_PORT & ~PORT_MASK) != 8'h00) || (WAIT_TIMEOUT < 1)) begin : g_bad_param
    $error("trs_port_bridge: BASE_PORT misaligned or WAIT_TIMEOUT < 1");
  end

  typedef enum logic [2:0] {ST_IDLE, ST_WR_STALL, ST_RD_WAIT, ST_RD_DRIVE, ST_END} state_t;
  state_t state, state_next;

  logic [16:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, rd_ahead;
  logic          full, pop, push, can_push, discard;
  logic [16:0]   push_data, pend_evt, pend_next;
  logic          armed, prev_active, active, start;
  logic          wait_q, wait_next, d_oe_q, d_oe_next;
  logic [7:0]    d_out_q, d_out_next;
  logic          rd_pushed, rd_mark, rd_clear;

  assign active   = ~bus.iorq_n & bus.m1_n & ((bus.a_in & PORT_MASK) == BASE_PORT)
                    & (~bus.wr_n | ~bus.rd_n);
  // armed stays low after reset until iorq_n is seen high, so a held strobe cannot trigger
  assign start    = armed & active & ~prev_active;
  assign full     = (count == CW'(FIFO_DEPTH));
  assign pop      = bus.evt_valid & bus.evt_ready;
  assign can_push = ~full | pop;

  assign bus.evt_valid = (count != '0);
  assign bus.evt_data  = bus.evt_valid ? mem[rd_ptr] : 17'h0;
  assign bus.d_out     = d_out_q;
  assign bus.d_oe      = d_oe_q;
  assign bus.wait_out  = wait_q;
  assign state_dbg     = state;

`ifdef TRS_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(WAIT_TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_fire;
  logic          tmo_flag_q;

  always_ff @(posedge clk_in) begin
    if (!reset_n || state != ST_RD_WAIT) tmo_cnt <= '0;
    else                                 tmo_cnt <= tmo_cnt + TW'(1);
    if (!reset_n)      tmo_flag_q <= 1'b0;
    else if (tmo_fire) tmo_flag_q <= 1'b1;
  end
  assign timeout_flag = tmo_flag_q;
`else
  assign timeout_flag = 1'b0;
`endif

  always_comb begin
    state_next = state;
    wait_next  = wait_q;
    d_oe_next  = d_oe_q;
    d_out_next = d_out_q;
    push       = 1'b0;
    push_data  = pend_evt;
    pend_next  = pend_evt;
    rd_mark    = 1'b0;
    rd_clear   = 1'b0;
    discard    = 1'b0;
`ifdef TRS_BRIDGE_TIMEOUT_EN
    tmo_fire   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (!bus.wr_n) begin
            push_data = {1'b0, bus.a_in, bus.d_in};
            pend_next = push_data;
            if (can_push) begin
              push       = 1'b1;
              state_next = ST_END;
            end else begin
              wait_next  = 1'b1;
              state_next = ST_WR_STALL;
            end
          end else begin
            push_data  = {1'b1, bus.a_in, 8'h00};
            pend_next  = push_data;
            wait_next  = 1'b1;
            state_next = ST_RD_WAIT;
            if (can_push) begin
              push    = 1'b1;
              rd_mark = 1'b1;
            end
          end
        end
      end
      ST_WR_STALL: begin
        if (can_push) begin
          push       = 1'b1;
          wait_next  = 1'b0;
          state_next = ST_END;
        end
      end
      ST_RD_WAIT: begin
        if (!rd_pushed) begin
          if (can_push) begin
            push    = 1'b1;
            rd_mark = 1'b1;
          end
        end else if (rd_ahead == '0 && bus.rsp_valid) begin
          d_out_next = bus.rsp_data;
          d_oe_next  = 1'b1;
          wait_next  = 1'b0;
          rd_clear   = 1'b1;
          state_next = ST_RD_DRIVE;
        end
`ifdef TRS_BRIDGE_TIMEOUT_EN
        // The read event is the newest entry while the Z80 is stalled, so dropping it is a tail pop
        if (state_next == ST_RD_WAIT && tmo_cnt == TW'(WAIT_TIMEOUT - 1)) begin
          push       = 1'b0;
          rd_mark    = 1'b0;
          discard    = rd_pushed && (rd_ahead != '0) && !(pop && rd_ahead == CW'(1));
          d_out_next = 8'hFF;
          d_oe_next  = 1'b1;
          wait_next  = 1'b0;
          rd_clear   = 1'b1;
          tmo_fire   = 1'b1;
          state_next = ST_RD_DRIVE;
        end
`endif
      end
      ST_RD_DRIVE: begin
        if (bus.iorq_n || bus.rd_n) begin
          d_oe_next  = 1'b0;
          state_next = ST_IDLE;
        end
      end
      ST_END: begin
        if (bus.iorq_n) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      armed       <= 1'b0;
      prev_active <= 1'b0;
      wait_q      <= 1'b0;
      d_oe_q      <= 1'b0;
      d_out_q     <= 8'h00;
      pend_evt    <= 17'h0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rd_pushed   <= 1'b0;
      rd_ahead    <= '0;
    end else begin
      state       <= state_next;
      prev_active <= active;
      if (bus.iorq_n) armed <= 1'b1;
      wait_q      <= wait_next;
      d_oe_q      <= d_oe_next;
      d_out_q     <= d_out_next;
      pend_evt    <= pend_next;
      if (push)         wr_ptr <= wr_ptr + AW'(1);
      else if (discard) wr_ptr <= wr_ptr - AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop) - CW'(discard);
      // rd_ahead = entries still to pop up to and including the pending read event
      if (rd_clear) begin
        rd_pushed <= 1'b0;
        rd_ahead  <= '0;
      end else if (rd_mark) begin
        rd_pushed <= 1'b1;
        rd_ahead  <= count + CW'(1) - CW'(pop);
      end else if (pop && rd_ahead != '0) begin
        rd_ahead  <= rd_ahead - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_trs_port_bridge.sv
// Directed bench for trs_port_bridge: event and response scoreboards checked by a monitor.
// The timeout scenario runs only when TRS_BRIDGE_TIMEOUT_EN is defined.
module tb_trs_port_bridge;
  logic       clk_in;
  logic       reset_n;
  logic       timeout_flag;
  logic [2:0] state_dbg;
  int         pass_cnt = 0;
  int         total_cnt = 0;

  logic [16:0] exp_q[$];
  logic [7:0]  rsp_q[$];
  logic        d_oe_prev = 1'b0;

  trs_port_bridge_if bus ();

  trs_port_bridge #(
    .BASE_PORT(8'hE0), .NUM_PORTS(8), .FIFO_DEPTH(16), .WAIT_TIMEOUT(64)
  ) dut (
    .clk_in(clk_in), .reset_n(reset_n), .bus(bus),
    .timeout_flag(timeout_flag), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic bus_idle();
    bus.a_in = 8'h00; bus.d_in = 8'h00;
    bus.iorq_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1; bus.m1_n = 1'b1;
  endtask

  task automatic start_write(input logic [7:0] p, input logic [7:0] d);
    bus.a_in = p; bus.d_in = d; bus.m1_n = 1'b1; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
    tick(1);
  endtask

  task automatic start_read(input logic [7:0] p);
    bus.a_in = p; bus.d_in = 8'h00; bus.m1_n = 1'b1; bus.iorq_n = 1'b0; bus.rd_n = 1'b0;
    tick(1);
  endtask

  task automatic end_cycle();
    bus.iorq_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1; bus.m1_n = 1'b1;
    tick(1);
  endtask

  task automatic io_write(input logic [7:0] p, input logic [7:0] d);
    start_write(p, d);
    tick(1);
    end_cycle();
  endtask

  task automatic drain();
    bus.evt_ready = 1'b1;
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) tick(1);
    bus.evt_ready = 1'b0;
    check("drain_queue_left", exp_q.size(), 0);
    check("drain_evt_valid", bus.evt_valid, 0);
  endtask

  // scoreboard monitor
  always @(negedge clk_in) begin
    if (reset_n && bus.evt_valid && bus.evt_ready) begin
      if (exp_q.size() == 0) check("evt_unexpected", bus.evt_data, 17'h1FFFF);
      else                   check("evt_data", bus.evt_data, exp_q.pop_front());
    end
    if (bus.d_oe && !d_oe_prev) begin
      if (rsp_q.size() == 0) check("d_out_unexpected", bus.d_out, 8'hXX);
      else                   check("d_out", bus.d_out, rsp_q.pop_front());
    end
    d_oe_prev <= bus.d_oe;
  end

  initial begin
    bus_idle();
    bus.evt_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_data = 8'h00;
    reset_n = 1'b0;
    tick(3);
    check("rst_d_out", bus.d_out, 8'h00);
    check("rst_d_oe", bus.d_oe, 0);
    check("rst_wait", bus.wait_out, 0);
    check("rst_evt_valid", bus.evt_valid, 0);
    check("rst_evt_data", bus.evt_data, 17'h0);
    check("rst_timeout_flag", timeout_flag, 0);
    reset_n = 1'b1;
    tick(1);

    // single OUT with empty FIFO
    start_write(8'hE3, 8'h5A);
    check("out1_evt_valid", bus.evt_valid, 1);
    check("out1_evt_data", bus.evt_data, {1'b0, 8'hE3, 8'h5A});
    check("out1_wait", bus.wait_out, 0);
    tick(1);
    check("out1_wait_hold", bus.wait_out, 0);
    end_cycle();
    exp_q.push_back({1'b0, 8'hE3, 8'h5A});
    drain();

    // fill FIFO, then stall one more OUT until a pop frees an entry
    for (int i = 0; i < 16; i++) begin
      io_write(8'hE0 + 8'(i % 8), 8'(8'h20 + i));
      exp_q.push_back({1'b0, 8'(8'hE0 + 8'(i % 8)), 8'(8'h20 + i)});
    end
    check("full_no_wait", bus.wait_out, 0);
    start_write(8'hE0, 8'h11);
    check("full_wait_on", bus.wait_out, 1);
    tick(2);
    check("full_wait_hold", bus.wait_out, 1);
    bus.evt_ready = 1'b1;
    tick(1);
    bus.evt_ready = 1'b0;
    check("refill_wait_off", bus.wait_out, 0);
    exp_q.push_back({1'b0, 8'hE0, 8'h11});
    end_cycle();
    check("refill_evt_valid", bus.evt_valid, 1);
    drain();

    // OUT then IN: order kept, early response ignored, response driven
    io_write(8'hE1, 8'h01);
    start_read(8'hE2);
    check("in_wait_on", bus.wait_out, 1);
    exp_q.push_back({1'b0, 8'hE1, 8'h01});
    exp_q.push_back({1'b1, 8'hE2, 8'h00});
    bus.rsp_valid = 1'b1; bus.rsp_data = 8'hAA;
    tick(1);
    bus.rsp_valid = 1'b0;
    check("early_rsp_d_oe", bus.d_oe, 0);
    check("early_rsp_wait", bus.wait_out, 1);
    drain();
    tick(2);
    check("in_wait_still", bus.wait_out, 1);
    rsp_q.push_back(8'hC3);
    bus.rsp_valid = 1'b1; bus.rsp_data = 8'hC3;
    tick(1);
    bus.rsp_valid = 1'b0;
    check("rsp_d_out", bus.d_out, 8'hC3);
    check("rsp_d_oe", bus.d_oe, 1);
    check("rsp_wait_off", bus.wait_out, 0);
    tick(2);
    check("drive_hold", bus.d_oe, 1);
    bus.rd_n = 1'b1;
    tick(1);
    check("drive_release", bus.d_oe, 0);
    end_cycle();

    // no decode: out-of-window ports and interrupt acknowledge
    io_write(8'hDF, 8'h33);
    check("miss_df_evt", bus.evt_valid, 0);
    io_write(8'hE8, 8'h44);
    check("miss_e8_evt", bus.evt_valid, 0);
    bus.a_in = 8'hE0; bus.m1_n = 1'b0; bus.iorq_n = 1'b0; bus.rd_n = 1'b0;
    tick(3);
    check("inta_evt", bus.evt_valid, 0);
    check("inta_wait", bus.wait_out, 0);
    end_cycle();

`ifdef TRS_BRIDGE_TIMEOUT_EN
    // IN with no response: forced completion after 64 cycles
    start_read(8'hE4);
    check("tmo_wait_on", bus.wait_out, 1);
    tick(63);
    check("tmo_wait_before", bus.wait_out, 1);
    check("tmo_flag_before", timeout_flag, 0);
    rsp_q.push_back(8'hFF);
    tick(1);
    check("tmo_d_out", bus.d_out, 8'hFF);
    check("tmo_d_oe", bus.d_oe, 1);
    check("tmo_wait_off", bus.wait_out, 0);
    check("tmo_flag", timeout_flag, 1);
    check("tmo_fifo_empty", bus.evt_valid, 0);
    bus.rsp_valid = 1'b1; bus.rsp_data = 8'h5C;
    tick(1);
    bus.rsp_valid = 1'b0;
    check("tmo_late_rsp", bus.d_out, 8'hFF);
    end_cycle();
    tick(2);
    check("tmo_flag_sticky", timeout_flag, 1);
`endif

    // reset in RD_WAIT with three events queued, strobe held through release
    io_write(8'hE5, 8'h01);
    io_write(8'hE6, 8'h02);
    start_read(8'hE7);
    tick(1);
    check("pre_rst_wait", bus.wait_out, 1);
    reset_n = 1'b0;
    tick(1);
    check("mid_rst_wait", bus.wait_out, 0);
    check("mid_rst_d_oe", bus.d_oe, 0);
    check("mid_rst_evt_valid", bus.evt_valid, 0);
    check("mid_rst_tmo_flag", timeout_flag, 0);
    reset_n = 1'b1;
    tick(3);
    check("held_no_retrig_evt", bus.evt_valid, 0);
    check("held_no_retrig_wait", bus.wait_out, 0);
    end_cycle();
    start_write(8'hE5, 8'h77);
    check("post_rst_evt_valid", bus.evt_valid, 1);
    tick(1);
    end_cycle();
    exp_q.push_back({1'b0, 8'hE5, 8'h77});
    drain();

    tick(2);
    check("rsp_queue_left", rsp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
